// File: rtl/score_keeper.sv
`default_nettype none
// ============================================================================
// Module   : score_keeper
// Brief    : Game scoreboard. Tracks the BCD score with saturation, lives, an
//            invulnerability window after a player hit, a one-shot bonus
//            life, sticky game-over and a session high score. All outputs
//            are registered so the HUD renderer can read them directly.
// Revision : 1.0 - initial release
// ============================================================================
module score_keeper #(
    parameter int DIGITS        = 4,
    parameter int LIFE_W        = 3,
    parameter int START_LIVES   = 3,
    parameter int MAX_LIVES     = 5,
    parameter int POINTS0       = 10,
    parameter int POINTS1       = 20,
    parameter int POINTS2       = 30,
    parameter int POINTS3       = 50,
    parameter int BONUS_BCD     = 'h1500,
    parameter int INVULN_FRAMES = 60
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  new_game,
    input  logic                  frame_tick,
    input  logic                  invader_collision,
    input  logic [1:0]            invader_type,
    input  logic                  player_collision,
    output logic [4*DIGITS-1:0]   score,
    output logic [4*DIGITS-1:0]   hi_score,
    output logic [LIFE_W-1:0]     lives,
    output logic                  game_over,
    output logic                  invuln,
    output logic                  bonus_pulse
);

    localparam int c_score_w = 4 * DIGITS;
    // The window counter must hold INVULN_FRAMES; keep at least one bit so
    // the design still elaborates when the window is disabled.
    localparam int c_cnt_w   = (INVULN_FRAMES < 2) ? 1 : $clog2(INVULN_FRAMES + 1);

    // Binary points (0..99) to a two-digit BCD byte, evaluated at elaboration.
    function automatic logic [7:0] to_bcd8(input int v);
        to_bcd8 = {4'(v / 10), 4'(v % 10)};
    endfunction

    localparam logic [7:0]           c_pts0        = to_bcd8(POINTS0);
    localparam logic [7:0]           c_pts1        = to_bcd8(POINTS1);
    localparam logic [7:0]           c_pts2        = to_bcd8(POINTS2);
    localparam logic [7:0]           c_pts3        = to_bcd8(POINTS3);
    localparam logic [c_score_w-1:0] c_bonus       = c_score_w'(BONUS_BCD);
    localparam logic                 c_bonus_en    = (BONUS_BCD != 0);
    localparam logic                 c_inv_en      = (INVULN_FRAMES != 0);
    localparam logic [c_cnt_w-1:0]   c_inv_frames  = c_cnt_w'(INVULN_FRAMES);
    localparam logic [LIFE_W-1:0]    c_start_lives = LIFE_W'(START_LIVES);
    localparam logic [LIFE_W-1:0]    c_max_lives   = LIFE_W'(MAX_LIVES);
    localparam logic [c_score_w-1:0] c_all_nines   = {DIGITS{4'h9}};

    logic [c_score_w-1:0] r_score;
    logic [c_score_w-1:0] r_hi_score;
    logic [LIFE_W-1:0]    r_lives;
    logic                 r_game_over;
    logic                 r_invuln;
    logic [c_cnt_w-1:0]   r_inv_cnt;
    logic                 r_bonus_given;
    logic                 r_bonus_pulse;

    logic [7:0]           w_pts;
    logic [c_score_w-1:0] w_addend;
    logic [c_score_w-1:0] w_sum;
    logic                 w_ovf;
    logic                 w_inv_hit;
    logic                 w_hit_acc;
    logic [c_score_w-1:0] w_score_next;
    logic                 w_bonus_cross;
    logic                 w_bonus_add;
    logic [LIFE_W-1:0]    w_lives_after_hit;
    logic [LIFE_W-1:0]    w_lives_next;

    // Look up the BCD value of the invader that was hit.
    always_comb begin
        w_pts = c_pts0;
        case (invader_type)
            2'd0:    w_pts = c_pts0;
            2'd1:    w_pts = c_pts1;
            2'd2:    w_pts = c_pts2;
            default: w_pts = c_pts3;
        endcase
    end

    // BCD ripple adder: each digit is corrected back into 0..9 with a carry
    // into the next; a carry out of the top digit means overflow.
    always_comb begin
        logic [4:0] dig;
        logic       carry;
        w_addend      = '0;
        w_addend[7:0] = w_pts;
        w_sum         = '0;
        carry         = 1'b0;
        dig           = '0;
        for (int i = 0; i < DIGITS; i++) begin
            dig = {1'b0, r_score[4*i +: 4]} + {1'b0, w_addend[4*i +: 4]} + {4'b0, carry};
            if (dig > 5'd9) begin
                w_sum[4*i +: 4] = 4'(dig - 5'd10);
                carry           = 1'b1;
            end else begin
                w_sum[4*i +: 4] = dig[3:0];
                carry           = 1'b0;
            end
        end
        w_ovf = carry;
    end

    // Event qualification: nothing counts once the game is over, and a
    // player hit only counts outside the window with lives remaining.
    assign w_inv_hit    = invader_collision & ~r_game_over;
    assign w_hit_acc    = player_collision & ~r_game_over & ~r_invuln & (r_lives != '0);
    assign w_score_next = w_inv_hit ? (w_ovf ? c_all_nines : w_sum) : r_score;

    // BCD compares correctly as unsigned binary, so the threshold crossing is
    // a plain magnitude test.
    assign w_bonus_cross = w_inv_hit & c_bonus_en & ~r_bonus_given &
                           (r_score < c_bonus) & (c_bonus <= w_score_next);

    // The hit is taken first; the bonus adds a life only while that stays
    // below the ceiling, so a same-cycle hit and bonus cancel.
    assign w_lives_after_hit = r_lives - LIFE_W'(w_hit_acc);
    assign w_bonus_add       = w_bonus_cross & (w_lives_after_hit < c_max_lives);
    assign w_lives_next      = w_lives_after_hit + LIFE_W'(w_bonus_add);

    // Scoreboard state: reset, restart, then per-cycle event updates.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_score       <= '0;
            r_hi_score    <= '0;
            r_lives       <= c_start_lives;
            r_game_over   <= 1'b0;
            r_invuln      <= 1'b0;
            r_inv_cnt     <= '0;
            r_bonus_given <= 1'b0;
            r_bonus_pulse <= 1'b0;
        end else if (new_game) begin
            r_score       <= '0;
            r_lives       <= c_start_lives;
            r_game_over   <= 1'b0;
            r_invuln      <= 1'b0;
            r_inv_cnt     <= '0;
            r_bonus_given <= 1'b0;
            r_bonus_pulse <= 1'b0;
        end else begin
            r_bonus_pulse <= 1'b0;
            if (!r_game_over) begin
                r_score       <= w_score_next;
                r_lives       <= w_lives_next;
                r_bonus_pulse <= w_bonus_add;
                if (w_bonus_cross) begin
                    r_bonus_given <= 1'b1;
                end
                if (w_hit_acc && (w_lives_next == '0)) begin
                    r_game_over <= 1'b1;
                    if (w_score_next > r_hi_score) begin
                        r_hi_score <= w_score_next;
                    end
                end else if (w_hit_acc && c_inv_en) begin
                    // A frame_tick in this same cycle is deliberately not counted.
                    r_invuln  <= 1'b1;
                    r_inv_cnt <= c_inv_frames;
                end else if (r_invuln && frame_tick) begin
                    r_inv_cnt <= r_inv_cnt - 1'b1;
                    if (r_inv_cnt == c_cnt_w'(1)) begin
                        r_invuln <= 1'b0;
                    end
                end
            end
        end
    end

    assign score       = r_score;
    assign hi_score    = r_hi_score;
    assign lives       = r_lives;
    assign game_over   = r_game_over;
    assign invuln      = r_invuln;
    assign bonus_pulse = r_bonus_pulse;

endmodule
`default_nettype wire

// File: tb/tb_score_keeper.sv
`default_nettype none
// ============================================================================
// Module   : tb_score_keeper
// Brief    : Directed self-checking bench for score_keeper. A second instance
//            starting at the lives ceiling shares the stimulus so the capped
//            bonus case is observed alongside the normal one.
// Revision : 1.0 - initial release
// ============================================================================
module tb_score_keeper;

    logic        clk;
    logic        rst;
    logic        new_game;
    logic        frame_tick;
    logic        invader_collision;
    logic [1:0]  invader_type;
    logic        player_collision;

    logic [15:0] score,  hi_score;
    logic [2:0]  lives;
    logic        game_over, invuln, bonus_pulse;

    logic [15:0] score2, hi_score2;
    logic [2:0]  lives2;
    logic        game_over2, invuln2, bonus_pulse2;

    int n_checks = 0;
    int n_fail   = 0;

    // Type 0 is worth 5 so that odd BCD scores such as 95 are reachable.
    score_keeper #(.POINTS0(5)) dut (
        .clk(clk), .rst(rst), .new_game(new_game), .frame_tick(frame_tick),
        .invader_collision(invader_collision), .invader_type(invader_type),
        .player_collision(player_collision),
        .score(score), .hi_score(hi_score), .lives(lives),
        .game_over(game_over), .invuln(invuln), .bonus_pulse(bonus_pulse)
    );

    score_keeper #(.POINTS0(5), .START_LIVES(5)) dut_cap (
        .clk(clk), .rst(rst), .new_game(new_game), .frame_tick(frame_tick),
        .invader_collision(invader_collision), .invader_type(invader_type),
        .player_collision(player_collision),
        .score(score2), .hi_score(hi_score2), .lives(lives2),
        .game_over(game_over2), .invuln(invuln2), .bonus_pulse(bonus_pulse2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stimulus drivers: change inputs on the falling edge, return on a
    // falling edge so outputs from the sampling edge are stable.
    task automatic inv_hit(input logic [1:0] t, input int hold = 1);
        @(negedge clk);
        invader_collision = 1'b1;
        invader_type      = t;
        repeat (hold - 1) @(negedge clk);
        @(negedge clk);
        invader_collision = 1'b0;
    endtask

    task automatic inv_hits(input logic [1:0] t, input int n);
        for (int k = 0; k < n; k++) inv_hit(t);
    endtask

    task automatic player_hit(input logic with_tick = 1'b0);
        @(negedge clk);
        player_collision = 1'b1;
        frame_tick       = with_tick;
        @(negedge clk);
        player_collision = 1'b0;
        frame_tick       = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            frame_tick = 1'b1;
            @(negedge clk);
            frame_tick = 1'b0;
        end
    endtask

    task automatic restart();
        @(negedge clk);
        new_game = 1'b1;
        @(negedge clk);
        new_game = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++; if (score !== 16'h0000) begin n_fail++; $display("FAIL reset_score got=%h exp=0000", score); end
        n_checks++; if (hi_score !== 16'h0000) begin n_fail++; $display("FAIL reset_hi got=%h exp=0000", hi_score); end
        n_checks++; if (lives !== 3'd3) begin n_fail++; $display("FAIL reset_lives got=%0d exp=3", lives); end
        n_checks++; if (game_over !== 1'b0) begin n_fail++; $display("FAIL reset_go got=%b exp=0", game_over); end
        n_checks++; if (invuln !== 1'b0) begin n_fail++; $display("FAIL reset_invuln got=%b exp=0", invuln); end
        n_checks++; if (bonus_pulse !== 1'b0) begin n_fail++; $display("FAIL reset_bonus got=%b exp=0", bonus_pulse); end
        rst = 1'b0;
        @(negedge clk);
        n_checks++; if (lives2 !== 3'd5) begin n_fail++; $display("FAIL reset_lives_cap got=%0d exp=5", lives2); end
    endtask

    task automatic test_bcd_add();
        inv_hit(2'd1, 2);   // held two cycles: counts twice, 40
        n_checks++; if (score !== 16'h0040) begin n_fail++; $display("FAIL b2b_hold got=%h exp=0040", score); end
        inv_hit(2'd3);      // 90
        inv_hit(2'd0);      // 95
        n_checks++; if (score !== 16'h0095) begin n_fail++; $display("FAIL bcd_95 got=%h exp=0095", score); end
        inv_hit(2'd3);      // 95 + 50 carries through two digits
        n_checks++; if (score !== 16'h0145) begin n_fail++; $display("FAIL bcd_145 got=%h exp=0145", score); end
    endtask

    task automatic test_bonus();
        inv_hit(2'd0);          // 150
        inv_hits(2'd3, 26);     // 1450
        inv_hits(2'd1, 2);      // 1490
        n_checks++; if (score !== 16'h1490) begin n_fail++; $display("FAIL pre_bonus got=%h exp=1490", score); end
        n_checks++; if (lives !== 3'd3) begin n_fail++; $display("FAIL pre_bonus_lives got=%0d exp=3", lives); end
        inv_hit(2'd2);          // 1520 crosses 1500
        n_checks++; if (score !== 16'h1520) begin n_fail++; $display("FAIL bonus_score got=%h exp=1520", score); end
        n_checks++; if (lives !== 3'd4) begin n_fail++; $display("FAIL bonus_lives got=%0d exp=4", lives); end
        n_checks++; if (bonus_pulse !== 1'b1) begin n_fail++; $display("FAIL bonus_pulse got=%b exp=1", bonus_pulse); end
        n_checks++; if (lives2 !== 3'd5) begin n_fail++; $display("FAIL cap_lives got=%0d exp=5", lives2); end
        n_checks++; if (bonus_pulse2 !== 1'b0) begin n_fail++; $display("FAIL cap_pulse got=%b exp=0", bonus_pulse2); end
        @(negedge clk);
        n_checks++; if (bonus_pulse !== 1'b0) begin n_fail++; $display("FAIL bonus_pulse_end got=%b exp=0", bonus_pulse); end
        n_checks++; if (lives !== 3'd4) begin n_fail++; $display("FAIL bonus_hold_lives got=%0d exp=4", lives); end
        inv_hit(2'd3);          // 1570, already past threshold: no second bonus
        n_checks++; if (lives !== 3'd4 || bonus_pulse !== 1'b0) begin n_fail++; $display("FAIL no_second_bonus lives=%0d pulse=%b exp=4/0", lives, bonus_pulse); end
    endtask

    task automatic test_saturation();
        inv_hits(2'd3, 168);    // 1570 + 8400 = 9970
        inv_hit(2'd1);          // 9990
        n_checks++; if (score !== 16'h9990) begin n_fail++; $display("FAIL pre_sat got=%h exp=9990", score); end
        inv_hit(2'd1);          // 10010 overflows
        n_checks++; if (score !== 16'h9999) begin n_fail++; $display("FAIL sat got=%h exp=9999", score); end
        inv_hit(2'd3);
        n_checks++; if (score !== 16'h9999) begin n_fail++; $display("FAIL sat_hold got=%h exp=9999", score); end
    endtask

    task automatic test_invuln();
        restart();
        n_checks++; if (score !== 16'h0000 || lives !== 3'd3) begin n_fail++; $display("FAIL restart score=%h lives=%0d exp=0000/3", score, lives); end
        player_hit(1'b1);       // same-cycle tick must not count
        n_checks++; if (lives !== 3'd2) begin n_fail++; $display("FAIL hit1_lives got=%0d exp=2", lives); end
        n_checks++; if (invuln !== 1'b1) begin n_fail++; $display("FAIL hit1_invuln got=%b exp=1", invuln); end
        ticks(10);
        player_hit();
        n_checks++; if (lives !== 3'd2) begin n_fail++; $display("FAIL invuln_block got=%0d exp=2", lives); end
        ticks(49);
        n_checks++; if (invuln !== 1'b1) begin n_fail++; $display("FAIL invuln_59 got=%b exp=1", invuln); end
        ticks(1);
        n_checks++; if (invuln !== 1'b0) begin n_fail++; $display("FAIL invuln_60 got=%b exp=0", invuln); end
        player_hit();
        n_checks++; if (lives !== 3'd1 || invuln !== 1'b1) begin n_fail++; $display("FAIL hit2 lives=%0d invuln=%b exp=1/1", lives, invuln); end
        ticks(60);
        inv_hits(2'd3, 4);      // 200, still scores
        player_hit();
        n_checks++; if (lives !== 3'd0 || game_over !== 1'b1) begin n_fail++; $display("FAIL go1 lives=%0d go=%b exp=0/1", lives, game_over); end
        n_checks++; if (hi_score !== 16'h0200) begin n_fail++; $display("FAIL go1_hi got=%h exp=0200", hi_score); end
    endtask

    task automatic test_game_over();
        restart();
        n_checks++; if (hi_score !== 16'h0200 || game_over !== 1'b0) begin n_fail++; $display("FAIL restart_hi hi=%h go=%b exp=0200/0", hi_score, game_over); end
        inv_hits(2'd3, 6);
        inv_hit(2'd1);          // 320
        player_hit();
        ticks(60);
        player_hit();
        ticks(60);
        n_checks++; if (lives !== 3'd1 || score !== 16'h0320) begin n_fail++; $display("FAIL pre_go lives=%0d score=%h exp=1/0320", lives, score); end
        player_hit();
        n_checks++; if (lives !== 3'd0 || game_over !== 1'b1) begin n_fail++; $display("FAIL go2 lives=%0d go=%b exp=0/1", lives, game_over); end
        n_checks++; if (hi_score !== 16'h0320) begin n_fail++; $display("FAIL go2_hi got=%h exp=0320", hi_score); end
        @(negedge clk);
        invader_collision = 1'b1; invader_type = 2'd3; player_collision = 1'b1; frame_tick = 1'b1;
        repeat (3) @(negedge clk);
        invader_collision = 1'b0; player_collision = 1'b0; frame_tick = 1'b0;
        @(negedge clk);
        n_checks++; if (score !== 16'h0320 || lives !== 3'd0) begin n_fail++; $display("FAIL go_ignore score=%h lives=%0d exp=0320/0", score, lives); end
        n_checks++; if (game_over !== 1'b1 || invuln !== 1'b0 || hi_score !== 16'h0320) begin n_fail++; $display("FAIL go_sticky go=%b inv=%b hi=%h exp=1/0/0320", game_over, invuln, hi_score); end
    endtask

    task automatic test_new_game();
        @(negedge clk);
        new_game = 1'b1; player_collision = 1'b1; invader_collision = 1'b1; invader_type = 2'd3;
        @(negedge clk);
        new_game = 1'b0; player_collision = 1'b0; invader_collision = 1'b0;
        n_checks++; if (score !== 16'h0000 || lives !== 3'd3) begin n_fail++; $display("FAIL ng score=%h lives=%0d exp=0000/3", score, lives); end
        n_checks++; if (game_over !== 1'b0 || hi_score !== 16'h0320 || invuln !== 1'b0) begin n_fail++; $display("FAIL ng_state go=%b hi=%h inv=%b exp=0/0320/0", game_over, hi_score, invuln); end
        player_hit();
        ticks(5);
        n_checks++; if (invuln !== 1'b1 || lives !== 3'd2) begin n_fail++; $display("FAIL pre_rst inv=%b lives=%0d exp=1/2", invuln, lives); end
        #2 rst = 1'b1;
        #1;
        n_checks++; if (invuln !== 1'b0) begin n_fail++; $display("FAIL async_rst_invuln got=%b exp=0", invuln); end
        n_checks++; if (hi_score !== 16'h0000 || lives !== 3'd3) begin n_fail++; $display("FAIL async_rst hi=%h lives=%0d exp=0000/3", hi_score, lives); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; new_game = 1'b0; frame_tick = 1'b0;
        invader_collision = 1'b0; invader_type = 2'd0; player_collision = 1'b0;
        test_reset();
        test_bcd_add();
        test_bonus();
        test_saturation();
        test_invuln();
        test_game_over();
        test_new_game();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout after %0d checks", n_checks);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/score_keeper.md
# score_keeper

Parametrised scoreboard for the game core: BCD score, lives, an invulnerability window after a player hit, a one-shot bonus life, sticky game-over and a session high score. It sits between the collision logic and the HUD/text renderer, replacing the fixed 2-digit-score, 2-bit-lives counter. All outputs are registered; the renderer reads them directly.

## Interface
Parameters:
- DIGITS, 4: BCD score digits; score width is 4*DIGITS; maximum score is 10^DIGITS−1 (all nines).
- LIFE_W, 3: lives counter width.
- START_LIVES, 3: lives after reset or new_game.
- MAX_LIVES, 5: lives ceiling. Requires 1 ≤ START_LIVES ≤ MAX_LIVES < 2^LIFE_W.
- POINTS0..POINTS3, 10/20/30/50: binary points per invader type (0–99), converted to two BCD digits at elaboration.
- BONUS_BCD, 'h1500: BCD score threshold for the single bonus life; 0 disables.
- INVULN_FRAMES, 60: frame_tick count of invulnerability after a non-fatal hit; 0 disables.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- new_game  in  1  synchronous restart pulse
- frame_tick  in  1  one-cycle pulse per video frame
- invader_collision  in  1  one-cycle pulse: player shot hit an invader
- invader_type  in  2  type of the hit invader, valid with invader_collision
- player_collision  in  1  one-cycle pulse: player was hit
- score  out  4*DIGITS  current score, BCD
- hi_score  out  4*DIGITS  best completed-game score since rst, BCD
- lives  out  LIFE_W  remaining lives
- game_over  out  1  sticky; set when lives reach 0
- invuln  out  1  invulnerability window active
- bonus_pulse  out  1  one-cycle pulse when the bonus life is awarded

## Operation
- rst (async): score=0, hi_score=0, lives=START_LIVES, game_over=0, invuln=0, invuln counter=0, bonus_given=0, bonus_pulse=0.
- new_game (sync, highest priority): same as rst except hi_score is kept. Same-cycle collisions are discarded.
- While game_over=1, invader_collision, player_collision and frame_tick are all ignored.
- Invader hit: score_next = score + POINTS[invader_type]. Use a BCD ripple add, per digit carry-corrected at >9. If the result exceeds 10^DIGITS−1, score saturates to all nines.
- Bonus: when bonus_given=0, BONUS_BCD≠0, and the score crosses the threshold (score < BONUS_BCD ≤ score_next, compared as unsigned, which is valid for BCD), set bonus_given. If lives would stay < MAX_LIVES, add 1 life and pulse bonus_pulse. bonus_given is set even when capped at MAX_LIVES, and no pulse is issued in that case.
- Player hit is accepted only if invuln=0 and lives>0.
- Lives update: lives_next = min(MAX_LIVES, lives − hit_acc + bonus). If a hit and a bonus land in the same cycle, they cancel.
- After an accepted hit:
  - If lives_next=0: set game_over. If score_next > hi_score, load hi_score ← score_next in the same cycle.
  - Else, if INVULN_FRAMES≠0: invuln←1 and counter←INVULN_FRAMES.
- Invuln counter: decrements on frame_tick while invuln=1. On the tick that takes it from 1 to 0, invuln clears. Invader hits still score during invuln.

## Timing
- Every event is reflected on the outputs on the clock edge that samples it (1-cycle latency); no back-pressure.
- Events are single-cycle pulses. A pulse held high for N cycles counts N times, and the upstream logic guarantees single-cycle pulses.
- bonus_pulse is high exactly one cycle, coincident with the lives increment.
- game_over and hi_score update on the same edge.
- With INVULN_FRAMES=K, invuln is high from the edge after the hit through the K-th subsequent frame_tick edge inclusive.
- A frame_tick in the same cycle as the accepted hit does not decrement the counter.
- rst asserted mid-window clears invuln immediately (asynchronously).

## Test plan
- Reset values: pulse rst → score=0, hi_score=0, lives=3, game_over=0, invuln=0, bonus_pulse=0.
- BCD add: score 'h0095 plus type-3 hit (50) → score 'h0145. Score 'h9990 plus type-1 hit (20) → score 'h9999 (saturated).
- Bonus: score 'h1490 plus type-2 hit (30) with lives=3 → score 'h1520, lives=4, bonus_pulse for 1 cycle. A later crossing gives no second bonus. With lives=5, no increment and no pulse.
- Invulnerability: hit at lives=3 → lives=2, invuln=1. Second hit before 60 frame_ticks → lives stay 2. After 60 ticks → invuln=0, and the next hit gives lives=1.
- Game over: hit at lives=1 with score 'h0320 and hi_score 'h0200 → lives=0, game_over=1, hi_score='h0320. Subsequent collisions leave all outputs unchanged.
- new_game: new_game with a player_collision in the same cycle → score=0, lives=3, game_over=0, hi_score kept at 'h0320. Then async rst mid-invuln → invuln=0 immediately, hi_score=0.
